tenary_conv_sequencer: RTL and testbench

Control sequencer for the ternary 3x3 adder datapath and its per-pixel accumulation line buffer. It runs one output line per `start` pulse. First it accepts one window beat per pixel for each input-channel group of TI channels. It drives accumulate/clear strobes aligned to the adder pipeline depth, and after the last group it drains the line buffer to the requantiser through a valid/ready handshake.

---
 rtl/tenary_ctrl_pkg.sv | 37 +++
 rtl/tenary_pipe_delay.sv | 44 ++++
 rtl/tenary_conv_sequencer.sv | 139 +++++++++++++
 tb/tb_tenary_conv_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tenary_ctrl_pkg.sv
// Shared types, defaults and elaboration helpers for the ternary conv sequencer.
// Parameter legality is checked at elaboration by the top through params_ok().
package tenary_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_TI = 3;
    localparam int ITER   = 1;

    function automatic int calc_iter(input int input_channel, input int ti);
        return input_channel / ti;
    endfunction

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    function automatic bit params_ok(input int input_size, input int ti,
                                     input int input_channel, input int addr_bits,
                                     input int pipe_lat);
        bit ok;
        ok = (ti >= 1) && (input_channel >= ti) && (input_channel % ti == 0);
        ok = ok && (input_channel / ti <= 255);
        ok = ok && (input_size >= 2) && (addr_bits >= 1) && (addr_bits <= 16);
        ok = ok && (input_size <= (1 << addr_bits));
        ok = ok && (pipe_lat >= 1) && (pipe_lat <= 8);
        return ok;
    endfunction

endpackage

// File: rtl/tenary_pipe_delay.sv
// Delay line that aligns accumulator strobes with the adder pipeline.
// Bubbles travel as valid=0; clr is masked by valid at the output.
module tenary_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_clr,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic          out_clr,
    output logic [AW-1:0] out_addr
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] clr_q;
    logic [AW-1:0]    addr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            clr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            clr_q[0]   <= in_clr;
            addr_q[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                clr_q[i]   <= clr_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_clr   = clr_q[DEPTH-1] & valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/tenary_conv_sequencer.sv
// Line sequencer for the ternary 3x3 adder: accumulates ITER channel groups
// per pixel into the line buffer, lets the pipeline retire, then drains it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; grp_idx reads 0
// ST_ACCUM | accepting window beats, pix/grp advance on each accept
// ST_FLUSH | no accepts; waits PIPE_LAT cycles for last strobe to retire
// ST_DRAIN | presenting drain_addr to the requantiser with out_valid
// ST_DONE  | single-cycle done pulse
module tenary_conv_sequencer
    import tenary_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE    = 16,
    parameter int TI            = DEF_TI,
    parameter int INPUT_CHANNEL = DEF_TI * ITER,
    parameter int ADDR_BITS     = 4,
    parameter int PIPE_LAT      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 acc_en,
    output logic                 acc_clr,
    output logic [ADDR_BITS-1:0] acc_addr,
    output logic [7:0]           grp_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] drain_addr
);

    localparam int N_ITER = calc_iter(INPUT_CHANNEL, TI);
    localparam int FW     = cnt_w(PIPE_LAT);

    localparam logic [ADDR_BITS-1:0] PIX_LAST   = ADDR_BITS'(INPUT_SIZE - 1);
    localparam logic [7:0]           GRP_LAST   = 8'(N_ITER - 1);
    localparam logic [FW-1:0]        FLUSH_LOAD = FW'(PIPE_LAT - 1);

    if (!params_ok(INPUT_SIZE, TI, INPUT_CHANNEL, ADDR_BITS, PIPE_LAT)) begin : g_bad_params
        $error("tenary_conv_sequencer: illegal parameter combination");
    end

    state_t               state;
    logic [ADDR_BITS-1:0] pix;
    logic [7:0]           grp;
    logic [FW-1:0]        flush_cnt;

    logic                 accept;
    logic                 push_clr;
    logic [ADDR_BITS-1:0] push_addr;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign grp_idx   = grp;

    assign accept    = in_valid & in_ready;
    assign push_clr  = accept & (grp == 8'd0);
    assign push_addr = accept ? pix : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pix        <= '0;
            grp        <= '0;
            flush_cnt  <= '0;
            drain_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACCUM;
                        pix   <= '0;
                        grp   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (pix == PIX_LAST) begin
                            pix <= '0;
                            // grp holds its last value through FLUSH/DRAIN for bank select
                            if (grp == GRP_LAST) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FLUSH_LOAD;
                            end else begin
                                grp <= grp + 8'd1;
                            end
                        end else begin
                            pix <= pix + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state      <= ST_DRAIN;
                        drain_addr <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (drain_addr == PIX_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            drain_addr <= drain_addr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    grp        <= '0;
                    drain_addr <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tenary_pipe_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (ADDR_BITS)
    ) u_pipe_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_clr    (push_clr),
        .in_addr   (push_addr),
        .out_valid (acc_en),
        .out_clr   (acc_clr),
        .out_addr  (acc_addr)
    );

endmodule

// File: tb/tb_tenary_conv_sequencer.sv
// Bench for tenary_conv_sequencer: table of line scenarios on a default
// instance plus a two-group instance and a mid-line reset sequence.
module tb_tenary_conv_sequencer;

    localparam int SIZE = 16;
    localparam int LAT  = 2;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic       busy, done, in_ready, acc_en, acc_clr, out_valid;
    logic [3:0] acc_addr, drain_addr;
    logic [7:0] grp_idx;

    logic       start6, in_valid6, out_ready6;
    logic       busy6, done6, in_ready6, acc_en6, acc_clr6, out_valid6;
    logic [3:0] acc_addr6, drain_addr6;
    logic [7:0] grp_idx6;

    always #5 clk = ~clk;

    tenary_conv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .acc_en(acc_en), .acc_clr(acc_clr),
        .acc_addr(acc_addr), .grp_idx(grp_idx), .out_valid(out_valid),
        .out_ready(out_ready), .drain_addr(drain_addr)
    );

    tenary_conv_sequencer #(.INPUT_CHANNEL(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6),
        .in_valid(in_valid6), .in_ready(in_ready6), .acc_en(acc_en6), .acc_clr(acc_clr6),
        .acc_addr(acc_addr6), .grp_idx(grp_idx6), .out_valid(out_valid6),
        .out_ready(out_ready6), .drain_addr(drain_addr6)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    typedef struct { int addr; int clr; int due; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int m_pix = 0, m_grp = 0, m_drain = 0;
    int busy_cnt = 0, done_cnt = 0, acc_cnt = 0, drain_cnt = 0;
    int cur_mode = 0;
    logic prev_acc = 1'b0, prev_stall = 1'b0;
    int prev_dr = 0;

    // Scoreboard for the default instance: expectations pushed on accept, popped on acc_en.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            m_pix = 0; m_grp = 0; m_drain = 0;
            prev_acc = 1'b0; prev_stall = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (acc_en) begin
                acc_cnt++;
                chk("acc_has_expect", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("acc_addr", int'(acc_addr), e.addr);
                    chk("acc_clr", int'(acc_clr), e.clr);
                    chk("acc_latency", cyc, e.due);
                end
                chk("acc_vs_drain", int'(out_valid), 0);
                if (cur_mode == 1) chk("acc_gap", int'(prev_acc), 0);
            end
            prev_acc = acc_en;
            if (in_valid && in_ready) begin
                chk("grp_idx", int'(grp_idx), m_grp);
                e.addr = m_pix; e.clr = (m_grp == 0) ? 1 : 0; e.due = cyc + LAT;
                q.push_back(e);
                if (m_pix == SIZE - 1) begin
                    m_pix = 0;
                    m_grp = 0;
                end else begin
                    m_pix++;
                end
            end
            if (prev_stall) begin
                chk("stall_hold_addr", int'(drain_addr), prev_dr);
                chk("stall_hold_valid", int'(out_valid), 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_dr    = drain_addr;
            if (out_valid && out_ready) begin
                drain_cnt++;
                chk("drain_addr", int'(drain_addr), m_drain);
                m_drain = (m_drain + 1) % SIZE;
            end
        end
    end

    int acc6_in = 0, acc6_out = 0, dr6 = 0, done6_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc6_in = 0; acc6_out = 0; dr6 = 0; done6_cnt = 0;
        end else begin
            if (in_valid6 && in_ready6) begin
                chk("g6_grp_idx", int'(grp_idx6), acc6_in / SIZE);
                acc6_in++;
            end
            if (acc_en6) begin
                chk("g6_acc_addr", int'(acc_addr6), acc6_out % SIZE);
                chk("g6_acc_clr", int'(acc_clr6), (acc6_out < SIZE) ? 1 : 0);
                acc6_out++;
            end
            if (out_valid6 && out_ready6) begin
                chk("g6_drain_addr", int'(drain_addr6), dr6);
                dr6++;
            end
            if (done6) done6_cnt++;
        end
    end

    task automatic run_line(input int mode, input int stall_len, input int inject);
        int c = 0;
        int stall_n = 0;
        bit got = 0;
        busy_cnt = 0; done_cnt = 0; acc_cnt = 0; drain_cnt = 0;
        cur_mode = mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_to_ready", int'(in_ready), 1);
        for (int k = 0; k < 300; k++) begin
            in_valid = in_ready && (mode == 0 || c % 2 == 0);
            start = (inject != 0) && ((in_ready && c == 4) || (out_valid && drain_addr == 4'd2));
            if (in_ready) c++;
            out_ready = !(out_valid && drain_addr == 4'd7 && stall_n < stall_len);
            if (!out_ready) stall_n++;
            if (done) got = 1;
            @(posedge clk); #1;
            if (got) break;
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        chk("line_done_seen", int'(got), 1);
        if (!got) begin
            $display("FAIL line_timeout: sequencer never reached done");
            $fatal(1);
        end
        chk("idle_after_done", int'(busy), 0);
    endtask

    typedef struct {
        int mode; int stall_len; int inject;
        int exp_busy; int exp_acc; int exp_drain; int exp_done;
    } vec_t;
    vec_t vecs[4];

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        start6 = 1'b0; in_valid6 = 1'b0; out_ready6 = 1'b1;

        vecs[0] = '{0, 0, 0, 35, 16, 16, 1};   // continuous
        vecs[1] = '{1, 0, 0, 50, 16, 16, 1};   // in_valid 1,0,1,0
        vecs[2] = '{0, 5, 0, 40, 16, 16, 1};   // out_ready low 5 cycles at 7
        vecs[3] = '{0, 0, 1, 35, 16, 16, 1};   // stray starts in ACCUM and DRAIN

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_grp_idx", int'(grp_idx), 0);
        chk("rst_drain_addr", int'(drain_addr), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            run_line(vecs[v].mode, vecs[v].stall_len, vecs[v].inject);
            chk("busy_cycles", busy_cnt, vecs[v].exp_busy);
            chk("acc_strobes", acc_cnt, vecs[v].exp_acc);
            chk("drain_beats", drain_cnt, vecs[v].exp_drain);
            chk("done_pulses", done_cnt, vecs[v].exp_done);
            chk("queue_empty", q.size(), 0);
        end

        // Reset in the middle of ACCUM once nine beats have been taken.
        cur_mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 40 && m_pix != 9; k++) begin
            @(posedge clk); #1;
        end
        chk("reached_pix9", m_pix, 9);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_acc_en", int'(acc_en), 0);
        chk("mid_rst_acc_clr", int'(acc_clr), 0);
        chk("mid_rst_acc_addr", int'(acc_addr), 0);
        chk("mid_rst_grp_idx", int'(grp_idx), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_acc", acc_cnt, 0);
        chk("post_rst_idle", int'(busy), 0);
        in_valid = 1'b0;

        run_line(0, 0, 0);
        chk("restart_busy", busy_cnt, 35);
        chk("restart_acc", acc_cnt, 16);
        chk("restart_done", done_cnt, 1);

        // Two channel groups on the second instance.
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0; in_valid6 = 1'b1;
        begin
            bit got6 = 0;
            for (int k = 0; k < 200 && !got6; k++) begin
                if (done6) got6 = 1;
                @(posedge clk); #1;
            end
            chk("g6_done_seen", int'(got6), 1);
        end
        in_valid6 = 1'b0;
        chk("g6_accepts", acc6_in, 32);
        chk("g6_strobes", acc6_out, 32);
        chk("g6_drains", dr6, 16);
        chk("g6_done_pulses", done6_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
